// File: rtl/pps_conditioner.sv
// Conditions raw GPS 1PPS: 2-FF sync, min-width glitch filter, period window check, lock FSM.
// Optional holdover flywheel enabled by defining PPS_HOLDOVER_EN.
module pps_conditioner #(
  parameter int CNT_BITS     = 12,
  parameter int NOMINAL      = 1000,
  parameter int TOL          = 4,
  parameter int MIN_HIGH     = 3,
  parameter int LOCK_COUNT   = 3,
  parameter int HOLDOVER_MAX = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pps_in,
  output logic                pps_out,
  output logic                locked,
  output logic                holdover,
  output logic [CNT_BITS-1:0] period_last,
  output logic [7:0]          miss_count
);

  localparam int RUN_W  = $clog2(MIN_HIGH + 1);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_BITS-1:0] P_MIN  = CNT_BITS'(NOMINAL - TOL);
  localparam logic [CNT_BITS-1:0] P_MAX  = CNT_BITS'(NOMINAL + TOL);
  localparam logic [CNT_BITS-1:0] P_ONES = '1;
`ifdef PPS_HOLDOVER_EN
  localparam logic [CNT_BITS-1:0] P_NOM     = CNT_BITS'(NOMINAL);
  localparam logic [CNT_BITS-1:0] P_TOL     = CNT_BITS'(TOL);
  localparam logic [CNT_BITS-1:0] P_REALIGN = CNT_BITS'(TOL + 1);
  localparam logic [7:0]          HO_MAX    = 8'(HOLDOVER_MAX);
`else
  localparam int unused_holdover_max = HOLDOVER_MAX;
`endif

  typedef enum logic [1:0] {ACQUIRE, LOCKED, HOLDOVER} state_t;

  state_t              state, state_nxt;
  logic                sync1, sync2;
  logic [RUN_W-1:0]    run_cnt, run_nxt;
  logic [GOOD_W-1:0]   good_cnt, good_nxt;
  logic [CNT_BITS-1:0] per_cnt, per_nxt, plast_nxt;
  logic [7:0]          miss_nxt;
  logic                accept, in_win, pulse;

  // Accept fires exactly once per high run: the cycle the run count reaches MIN_HIGH.
  assign accept = sync2 && (run_cnt == RUN_W'(MIN_HIGH - 1));
  assign in_win = (per_cnt >= P_MIN) && (per_cnt <= P_MAX);

  always_comb begin
    run_nxt = run_cnt;
    if (!sync2)
      run_nxt = '0;
    else if (run_cnt != RUN_W'(MIN_HIGH))
      run_nxt = run_cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    miss_nxt  = miss_count;
    plast_nxt = period_last;
    pulse     = 1'b0;
    per_nxt   = (per_cnt == P_ONES) ? per_cnt : per_cnt + 1'b1;
    case (state)
      ACQUIRE: begin
        if (accept) begin
          pulse     = 1'b1;
          per_nxt   = CNT_BITS'(1);
          plast_nxt = per_cnt;
          if (!in_win)
            good_nxt = '0;
          else if (good_cnt == GOOD_W'(LOCK_COUNT - 1)) begin
            good_nxt  = '0;
            miss_nxt  = '0;
            state_nxt = LOCKED;
          end else
            good_nxt = good_cnt + 1'b1;
        end
      end
      LOCKED: begin
        // Early edges fall through untouched; per_cnt keeps running.
        if (accept && in_win) begin
          pulse     = 1'b1;
          per_nxt   = CNT_BITS'(1);
          plast_nxt = per_cnt;
          miss_nxt  = '0;
        end else if (per_cnt == P_MAX) begin
`ifdef PPS_HOLDOVER_EN
          pulse     = 1'b1;
          per_nxt   = P_REALIGN;
          miss_nxt  = 8'd1;
          state_nxt = HOLDOVER;
`else
          good_nxt  = '0;
          state_nxt = ACQUIRE;
`endif
        end
      end
`ifdef PPS_HOLDOVER_EN
      HOLDOVER: begin
        if (accept && per_cnt >= P_MIN) begin
          pulse     = 1'b1;
          per_nxt   = CNT_BITS'(1);
          plast_nxt = per_cnt;
          miss_nxt  = '0;
          state_nxt = LOCKED;
        end else if (accept && per_cnt <= P_TOL) begin
          miss_nxt  = '0;
          state_nxt = LOCKED;
        end else if (per_cnt == P_NOM) begin
          if (miss_count == HO_MAX) begin
            good_nxt  = '0;
            state_nxt = ACQUIRE;
          end else begin
            pulse    = 1'b1;
            per_nxt  = CNT_BITS'(1);
            miss_nxt = (miss_count == 8'hFF) ? miss_count : miss_count + 8'd1;
          end
        end
      end
`endif
      default: state_nxt = ACQUIRE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      run_cnt     <= '0;
      state       <= ACQUIRE;
      good_cnt    <= '0;
      per_cnt     <= P_ONES;
      pps_out     <= 1'b0;
      period_last <= '0;
      miss_count  <= '0;
    end else begin
      sync1       <= pps_in;
      sync2       <= sync1;
      run_cnt     <= run_nxt;
      state       <= state_nxt;
      good_cnt    <= good_nxt;
      per_cnt     <= per_nxt;
      pps_out     <= pulse;
      period_last <= plast_nxt;
      miss_count  <= miss_nxt;
    end
  end

  assign locked = (state != ACQUIRE);
`ifdef PPS_HOLDOVER_EN
  assign holdover = (state == HOLDOVER);
`else
  assign holdover = 1'b0;
`endif

endmodule

// File: tb/tb_pps_conditioner.sv
// Bench for pps_conditioner: stimulus queues expected pulses, a negedge monitor checks them.
// Raw edges are driven 1 time unit after posedge N; the pulse is expected at cycle N+5.
module tb_pps_conditioner;

  logic        clk;
  logic        reset;
  logic        pps_in;
  logic        pps_out;
  logic        locked;
  logic        holdover;
  logic [11:0] period_last;
  logic [7:0]  miss_count;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {
    int          cyc;
    logic [11:0] plast;
    logic        lk;
    logic        ho;
    logic [7:0]  miss;
  } exp_t;
  exp_t exp_q[$];

  pps_conditioner dut (
    .clk(clk), .reset(reset), .pps_in(pps_in), .pps_out(pps_out),
    .locked(locked), .holdover(holdover), .period_last(period_last), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pps_out must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && pps_out === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got pps_out=1 want 0", cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc || period_last !== e.plast || locked !== e.lk ||
            holdover !== e.ho || (e.lk && miss_count !== e.miss)) begin
          errors++;
          $display("FAIL pulse got cyc=%0d plast=%0d lk=%b ho=%b miss=%0d want cyc=%0d plast=%0d lk=%b ho=%b miss=%0d",
                   cyc, period_last, locked, holdover, miss_count,
                   e.cyc, e.plast, e.lk, e.ho, e.miss);
        end
      end
    end
  end

  task automatic push(input int c, input int pl, input logic lk, input logic ho, input int m);
    exp_t e;
    e.cyc = c; e.plast = 12'(pl); e.lk = lk; e.ho = ho; e.miss = 8'(m);
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < t);
  endtask

  task automatic chk_at(input int t);
    wait_cyc(t);
    @(negedge clk);
  endtask

  task automatic raw_pulse(input int t, input int w);
    wait_cyc(t);
    pps_in = 1'b1;
    wait_cyc(t + w);
    pps_in = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    vectors++;
    if (pps_out !== 1'b0 || locked !== 1'b0 || holdover !== 1'b0 ||
        period_last !== 12'd0 || miss_count !== 8'd0) begin
      errors++;
      $display("FAIL %s got pps=%b lk=%b ho=%b plast=%0d miss=%0d want all 0",
               nm, pps_out, locked, holdover, period_last, miss_count);
    end
  endtask

  task automatic check_lk(input string nm, input logic lk, input logic ho);
    vectors++;
    if (locked !== lk || holdover !== ho) begin
      errors++;
      $display("FAIL %s cyc=%0d got lk=%b ho=%b want lk=%b ho=%b", nm, cyc, locked, holdover, lk, ho);
    end
  endtask

  // Four nominal edges from ACQUIRE; lock is reported with the fourth pulse.
  task automatic relock(input int t, input int first_plast);
    push(t + 5,    first_plast, 1'b0, 1'b0, 0);
    push(t + 1005, 1000,        1'b0, 1'b0, 0);
    push(t + 2005, 1000,        1'b0, 1'b0, 0);
    push(t + 3005, 1000,        1'b1, 1'b0, 0);
    for (int k = 0; k < 4; k++)
      raw_pulse(t + k * 1000, 10);
  endtask

  initial begin
    int t0, a, r;
    reset  = 1'b1;
    pps_in = 1'b0;
    #2;
    check_zero("reset_state");
    wait_cyc(5);
    reset = 1'b0;

    t0 = 100;
    relock(t0, 4095);

    raw_pulse(t0 + 3300, 2);                 // glitch shorter than MIN_HIGH
    push(t0 + 4005, 1000, 1'b1, 1'b0, 0);
    raw_pulse(t0 + 4000, 10);

    raw_pulse(t0 + 4500, 10);                // early edge while locked
    push(t0 + 5005, 1000, 1'b1, 1'b0, 0);
    raw_pulse(t0 + 5000, 3);                 // exactly MIN_HIGH wide

    push(t0 + 6009, 1004, 1'b1, 1'b0, 0);    // upper window edge
    raw_pulse(t0 + 6004, 10);
    push(t0 + 7005, 996, 1'b1, 1'b0, 0);     // lower window edge
    raw_pulse(t0 + 7000, 10);
    a = t0 + 7005;

`ifdef PPS_HOLDOVER_EN
    push(a + 1004, 996, 1'b1, 1'b1, 1);
    push(a + 2000, 996, 1'b1, 1'b1, 2);
    chk_at(a + 2999);
    check_lk("holdover_before_drop", 1'b1, 1'b1);
    chk_at(a + 3000);
    check_lk("holdover_drop", 1'b0, 1'b0);
    relock(a + 3500, 1505);
    push(a + 3500 + 4009, 1000, 1'b1, 1'b1, 1);
    wait_cyc(a + 3500 + 4500);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("reset_in_holdover");
    wait_cyc(a + 3500 + 4503);
    reset = 1'b0;
    r = a + 3500 + 4600;
`else
    chk_at(a + 1003);
    check_lk("locked_before_miss", 1'b1, 1'b0);
    chk_at(a + 1004);
    check_lk("miss_unlock", 1'b0, 1'b0);
    wait_cyc(a + 1500);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("reset_after_miss");
    wait_cyc(a + 1503);
    reset = 1'b0;
    r = a + 1600;
`endif

    relock(r, 4095);
    chk_at(r + 3050);
    check_lk("relocked", 1'b1, 1'b0);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses got %0d outstanding want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog cyc=%0d got timeout want completion", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

endmodule
